// File: rtl/hash_client_pkg.sv
// Shared types for the hash client: handshake FSM state encoding.
`include "def.svh"

package hash_client_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_OUT     = 3'd4
  } hash_client_state_t;

endpackage

// File: rtl/def.svh
// Shared bus widths and literal helpers for the hash client slice.
`ifndef DEF_SVH
`define DEF_SVH

`define QUAD_BUS  [63:0]
`define DATA_BUS  [31:0]
`define TRUE      1'b1
`define FALSE     1'b0
`define ZERO_WORD 32'h0000_0000

`endif

// File: rtl/key_fifo.sv
// Key queue for the hash client; pointers carry an extra wrap bit so full and
// empty are distinguishable. A pop frees a slot for a push in the same cycle.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset: contents are only observed behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hash_client.sv
// Queues keys and drives a level-start hash engine one job at a time.
// Optional watchdog in WAIT enabled by HASH_CLIENT_TIMEOUT_EN.
`include "def.svh"

module hash_client
  import hash_client_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid_i,
  input  logic `QUAD_BUS key_i,
  output logic           key_ready_o,
  output logic           start_o,
  output logic `QUAD_BUS key_o,
  input  logic           hash_ready_i,
  input  logic `DATA_BUS hash_val_i,
  output logic           res_valid_o,
  input  logic           res_ready_i,
  output logic `QUAD_BUS res_key_o,
  output logic `DATA_BUS res_hash_o,
  output logic           res_err_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("hash_client: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  hash_client_state_t state, state_nxt;
  logic               start_nxt, res_valid_nxt;
  logic `QUAD_BUS     key_nxt, res_key_nxt, fifo_head;
  logic `DATA_BUS     res_hash_nxt;
  logic               fifo_full, fifo_empty, pop;

  // Popping only from IDLE keeps a key pushed this cycle out of reach until next.
  assign pop         = (state == S_IDLE) && !fifo_empty;
  assign key_ready_o = !fifo_full || pop;

  key_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid_i),
    .din   (key_i),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef HASH_CLIENT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdog;
  logic            err_q, err_nxt, timeout;

  assign timeout   = (state == S_WAIT) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign res_err_o = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  wdog <= '0;
    else if (state == S_WAIT && !hash_ready_i) wdog <= wdog + WD_W'(1);
    else                                       wdog <= '0;
  end
`else
  assign res_err_o = `FALSE;
`endif

  always_comb begin
    state_nxt     = state;
    start_nxt     = start_o;
    key_nxt       = key_o;
    res_valid_nxt = res_valid_o;
    res_key_nxt   = res_key_o;
    res_hash_nxt  = res_hash_o;
`ifdef HASH_CLIENT_TIMEOUT_EN
    err_nxt       = err_q;
`endif
    case (state)
      S_IDLE: if (!fifo_empty) begin
        key_nxt   = fifo_head;
        start_nxt = `TRUE;
        state_nxt = S_ARM;
      end
      // Ready seen here may still belong to the previous job.
      S_ARM: state_nxt = S_WAIT;
      S_WAIT: begin
        if (hash_ready_i) begin
          res_hash_nxt = hash_val_i;
          res_key_nxt  = key_o;
          start_nxt    = `FALSE;
          state_nxt    = S_RELEASE;
`ifdef HASH_CLIENT_TIMEOUT_EN
          err_nxt      = `FALSE;
        end else if (timeout) begin
          res_hash_nxt = `ZERO_WORD;
          res_key_nxt  = key_o;
          err_nxt      = `TRUE;
          start_nxt    = `FALSE;
          state_nxt    = S_RELEASE;
`endif
        end
      end
      S_RELEASE: begin
        res_valid_nxt = `TRUE;
        state_nxt     = S_OUT;
      end
      S_OUT: if (res_ready_i) begin
        res_valid_nxt = `FALSE;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      start_o     <= `FALSE;
      key_o       <= '0;
      res_valid_o <= `FALSE;
      res_key_o   <= '0;
      res_hash_o  <= `ZERO_WORD;
`ifdef HASH_CLIENT_TIMEOUT_EN
      err_q       <= `FALSE;
`endif
    end else begin
      state       <= state_nxt;
      start_o     <= start_nxt;
      key_o       <= key_nxt;
      res_valid_o <= res_valid_nxt;
      res_key_o   <= res_key_nxt;
      res_hash_o  <= res_hash_nxt;
`ifdef HASH_CLIENT_TIMEOUT_EN
      err_q       <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_hash_client.sv
// Directed bench for hash_client with a byte-sum reference engine that answers
// one cycle after seeing start; manual ready/value drive for corner cases.
module tb_hash_client;

  logic        clk = 0, rst = 0;
  logic        key_valid_i = 0;
  logic [63:0] key_i = '0;
  logic        key_ready_o, start_o;
  logic [63:0] key_o;
  logic        hash_ready_i;
  logic [31:0] hash_val_i;
  logic        res_valid_o;
  logic        res_ready_i = 0;
  logic [63:0] res_key_o;
  logic [31:0] res_hash_o;
  logic        res_err_o;

  logic        eng_en = 1, eng_rdy = 0, man_rdy = 0;
  logic [31:0] eng_val = '0, man_val = '0;

  int n_chk = 0, n_err = 0;
  logic [63:0] q_key[$];
  logic [31:0] q_hash[$];
  logic [63:0] exp_k[8];
  logic [31:0] exp_h[8];

  always #5 clk = ~clk;

  assign hash_ready_i = eng_en ? eng_rdy : man_rdy;
  assign hash_val_i   = eng_en ? eng_val : man_val;

  hash_client #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid_i  (key_valid_i),
    .key_i        (key_i),
    .key_ready_o  (key_ready_o),
    .start_o      (start_o),
    .key_o        (key_o),
    .hash_ready_i (hash_ready_i),
    .hash_val_i   (hash_val_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_key_o    (res_key_o),
    .res_hash_o   (res_hash_o),
    .res_err_o    (res_err_o)
  );

  function automatic logic [31:0] bsum(input logic [63:0] k);
    logic [31:0] s = '0;
    for (int i = 0; i < 8; i++) s += {24'd0, k[i*8 +: 8]};
    return s;
  endfunction

  // Reference engine: returns to free (ready low) whenever start is low.
  always @(posedge clk) begin
    if (!start_o) eng_rdy <= 1'b0;
    else begin
      eng_rdy <= 1'b1;
      eng_val <= bsum(key_o);
    end
  end

  always @(negedge clk) begin
    if (rst && res_valid_o && res_ready_i) begin
      q_key.push_back(res_key_o);
      q_hash.push_back(res_hash_o);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync;
    @(posedge clk); #1;
  endtask

  // Call just after a rising edge; returns just after the edge that took the key.
  task automatic push(input logic [63:0] k);
    bit done = 0;
    key_i = k;
    key_valid_i = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (key_ready_o) done = 1;
    end
    if (done) begin
      @(posedge clk); #1;
    end else chk("push_timeout", 0, 1);
    key_valid_i = 0;
  endtask

  task automatic wait_res(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (res_valid_o) seen = 1;
    end
    if (!seen) chk("res_timeout", 0, 1);
  endtask

  task automatic wait_start(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (start_o) seen = 1;
    end
    if (!seen) chk("start_timeout", 0, 1);
  endtask

  task automatic check_q(input string tag, input int n);
    for (int i = 0; i < 400 && q_key.size() < n; i++) @(negedge clk);
    chk({tag, "_count"}, q_key.size(), n);
    for (int i = 0; i < n && i < q_key.size(); i++) begin
      chk($sformatf("%s_key%0d", tag, i), q_key[i], exp_k[i]);
      chk($sformatf("%s_hash%0d", tag, i), q_hash[i], exp_h[i]);
    end
  endtask

  initial begin
    int n_hi, lat, bad;
    logic [63:0] hold_k;
    logic [31:0] hold_h;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start", start_o, 0);
    chk("rst_key_o", key_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_key", res_key_o, 0);
    chk("rst_res_hash", res_hash_o, 0);
    chk("rst_res_err", res_err_o, 0);
    chk("rst_key_ready", key_ready_o, 1);
    rst = 1;
    res_ready_i = 1;
    sync;

    // Single key through the reference engine
    push(64'h0102030405060708);
    n_hi = 0; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (start_o) n_hi++;
      if (res_valid_o && lat == 0) begin
        lat = i;
        chk("t1_hash", res_hash_o, 32'h24);
        chk("t1_key", res_key_o, 64'h0102030405060708);
        chk("t1_err", res_err_o, 0);
      end
    end
    chk("t1_start_hi", n_hi, 2);
    chk("t1_latency", lat, 5);  // pop cycle + 4
    sync;

    // Five back-to-back keys, depth 4
    q_key.delete(); q_hash.delete();
    exp_k[0] = 64'h1111111111111111; exp_h[0] = 32'h88;
    exp_k[1] = 64'hFFFFFFFFFFFFFFFF; exp_h[1] = 32'h7F8;
    exp_k[2] = 64'h0000000000000000; exp_h[2] = 32'h0;
    exp_k[3] = 64'h8000000000000001; exp_h[3] = 32'h81;
    exp_k[4] = 64'hDEADBEEFCAFEF00D; exp_h[4] = 32'h5FD;
    for (int i = 0; i < 5; i++) push(exp_k[i]);
    @(negedge clk);
    chk("t2_full_ready", key_ready_o, 0);
    check_q("t2", 5);
    sync;

    // Stale ready at ARM entry
    eng_en = 0; man_rdy = 1; man_val = 32'h0000_0BAD;
    push(64'h0A0B0C0D0E0F1011);
    wait_start(20);
    sync;
    man_rdy = 0;
    @(negedge clk);
    chk("t3_no_arm_capture", start_o, 1);
    chk("t3_no_early_valid", res_valid_o, 0);
    repeat (3) @(negedge clk);
    chk("t3_still_waiting", start_o, 1);
    sync;
    man_val = 32'h1234_5678; man_rdy = 1;
    wait_res(10);
    man_rdy = 0;
    chk("t3_hash", res_hash_o, 32'h1234_5678);
    chk("t3_key", res_key_o, 64'h0A0B0C0D0E0F1011);
    repeat (3) sync;

    // Downstream stall; FIFO fills, then push alongside a pop on full
    eng_en = 1; res_ready_i = 0;
    q_key.delete(); q_hash.delete();
    exp_k[0] = 64'h0101010101010101; exp_h[0] = 32'h8;
    exp_k[1] = 64'h0202020202020202; exp_h[1] = 32'h10;
    exp_k[2] = 64'h00000000000000FF; exp_h[2] = 32'hFF;
    exp_k[3] = 64'hFF00000000000000; exp_h[3] = 32'hFF;
    exp_k[4] = 64'h0000000100000001; exp_h[4] = 32'h2;
    exp_k[5] = 64'h7F7F7F7F7F7F7F7F; exp_h[5] = 32'h3F8;
    push(exp_k[0]);
    wait_res(20);
    hold_k = res_key_o; hold_h = res_hash_o;
    chk("t4_hold_hash", hold_h, 32'h8);
    sync;
    for (int i = 1; i < 5; i++) push(exp_k[i]);
    @(negedge clk);
    chk("t4_full_ready", key_ready_o, 0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (!res_valid_o || res_key_o != hold_k || res_hash_o != hold_h || start_o) bad++;
    end
    chk("t4_stall_stable", bad, 0);
    sync;
    res_ready_i = 1;
    push(exp_k[5]);
    check_q("t4", 6);
    sync;

    // Reset pulse during WAIT
    eng_en = 0; man_rdy = 0;
    push(64'hAAAA_0000_0000_0001);
    push(64'hAAAA_0000_0000_0002);
    push(64'hAAAA_0000_0000_0003);
    @(negedge clk);
    chk("t5_in_wait", start_o, 1);
    #2 rst = 0;
    #1;
    chk("t5_rst_start", start_o, 0);
    chk("t5_rst_key_o", key_o, 0);
    chk("t5_rst_ready", key_ready_o, 1);
    sync;
    rst = 1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (start_o || res_valid_o) bad++;
    end
    chk("t5_quiet_after_rst", bad, 0);
    chk("t5_fifo_empty", key_ready_o, 1);
    sync;

`ifdef HASH_CLIENT_TIMEOUT_EN
    // Watchdog expiry with the engine silent
    push(64'h5555_6666_7777_8888);
    n_hi = 0; lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (start_o) n_hi++;
      if (res_valid_o) lat = i;
    end
    chk("t6_valid", res_valid_o, 1);
    chk("t6_err", res_err_o, 1);
    chk("t6_hash", res_hash_o, 0);
    chk("t6_key", res_key_o, 64'h5555_6666_7777_8888);
    chk("t6_start_hi", n_hi, 9);
`else
    // Without the watchdog a silent engine keeps the job waiting
    push(64'h5555_6666_7777_8888);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid_o) bad++;
    end
    chk("t6_no_result", bad, 0);
    chk("t6_still_start", start_o, 1);
    chk("t6_err_tied", res_err_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
